y86_fetch_decode: RTL and testbench

- Single-cycle Y86-64 front end: instruction fetch plus decode/register-file read.
- Fetch: a byte-addressed instruction memory is indexed by PC_i. The block splits the instruction into icode/ifunc/rA/rB/valC, computes valP and flags invalid instructions and memory faults.
- Decode: selects source registers per icode and reads valA/valB from a 15-entry 64-bit register file. The register file is written by a write-back port from downstream stages.
- Sits between the PC register and the execute stage.

---
 rtl/y86_pkg.sv | 59 +++++
 rtl/y86_regfile.sv | 50 +++++
 rtl/y86_fetch_decode.sv | 127 ++++++++++++
 tb/tb_y86_fetch_decode.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the fetch/decode front end.
// Instruction codes, register IDs, lengths, ifunc limits and helpers.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] LEN1  = 4'd1;
  localparam logic [3:0] LEN2  = 4'd2;
  localparam logic [3:0] LEN9  = 4'd9;
  localparam logic [3:0] LEN10 = 4'd10;

  localparam logic [3:0] ALU_FN_MAX = 4'd3;
  localparam logic [3:0] CC_FN_MAX  = 4'd6;

  function automatic logic [3:0] instrLen(input logic [3:0] ic);
    logic [3:0] l;
    l = LEN1;
    unique case (1'b1)
      (ic inside {IRRMOVQ, IOPQ, IPUSHQ, IPOPQ}): l = LEN2;
      (ic inside {IJXX, ICALL}):                 l = LEN9;
      (ic inside {IIRMOVQ, IRMMOVQ, IMRMOVQ}):   l = LEN10;
      default:                                   l = LEN1;
    endcase
    return l;
  endfunction

  function automatic logic instrOk(input logic [3:0] ic,
                                   input logic [3:0] fn);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (ic inside {IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                  ICALL, IRET, IPUSHQ, IPOPQ}):
        ok = (fn == 4'h0);
      (ic inside {IRRMOVQ, IJXX}):
        ok = (fn <= CC_FN_MAX);
      (ic == IOPQ):
        ok = (fn <= ALU_FN_MAX);
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: two async reads, E/M write ports (M wins).
// Ports: clk, rst, srcA/srcB -> valA/valB, dstE/valE, dstM/valM.
// Y86_REG_BYPASS_EN forwards same-cycle write data to the reads.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB
);

  logic [63:0] regs [15];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (dstE != RNONE) regs[dstE] <= valE;
      // later assignment wins when dstM == dstE
      if (dstM != RNONE) regs[dstM] <= valM;
    end
  end

  function automatic logic [63:0] rd(input logic [3:0] s);
    logic [63:0] v;
    v = '0;
    if (s != RNONE) v = regs[s];
`ifdef Y86_REG_BYPASS_EN
    // nothing is written on a reset edge, so nothing to forward
    if (!rst && s != RNONE) begin
      if (s == dstM)      v = valM;
      else if (s == dstE) v = valE;
    end
`endif
    return v;
  endfunction

  always_comb begin
    valA = rd(srcA);
    valB = rd(srcB);
  end

endmodule

// File: rtl/y86_fetch_decode.sv
// Single-cycle Y86-64 fetch + decode with byte imem and regfile.
// Ports: PC_i, imem load port, E/M write-back -> decoded fields, valA/B.
// Y86_REG_BYPASS_EN enables same-cycle write-back forwarding.
module y86_fetch_decode
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] PC_i,
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [7:0]  imem_wdata_i,
  input  logic [3:0]  dstE_i,
  input  logic [63:0] valE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valM_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifunc_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        imem_error_o,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o
);

  localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] MEM_END = 64'(IMEM_BYTES);

  logic [7:0] imem [IMEM_BYTES];

  always_ff @(posedge clk_i) begin
    if (imem_we_i && imem_waddr_i < MEM_END)
      imem[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
  end

  logic [9:0][7:0] fb;

  // out-of-range bytes read as 0; the error flag masks them anyway
  always_comb begin
    logic [63:0] a;
    a  = '0;
    fb = '0;
    for (int k = 0; k < 10; k++) begin
      a = PC_i + 64'(k);
      fb[k] = (a < MEM_END) ? imem[a[AW-1:0]] : 8'h00;
    end
  end

  logic [3:0] rawIc;
  logic [3:0] rawFn;
  logic [3:0] len;
  logic       err;

  assign rawIc = fb[0][7:4];
  assign rawFn = fb[0][3:0];
  assign len   = instrLen(rawIc);

  // PC+len-1 >= END rewritten as END-PC < len to avoid overflow
  assign err = (PC_i >= MEM_END) || ((MEM_END - PC_i) < 64'(len));

  always_comb begin
    icode_o       = rawIc;
    ifunc_o       = rawFn;
    rA_o          = RNONE;
    rB_o          = RNONE;
    valC_o        = '0;
    valP_o        = PC_i + 64'(len);
    instr_valid_o = instrOk(rawIc, rawFn);
    imem_error_o  = err;
    if (rawIc inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
                      IOPQ, IPUSHQ, IPOPQ}) begin
      rA_o = fb[1][7:4];
      rB_o = fb[1][3:0];
    end
    unique case (1'b1)
      (rawIc inside {IIRMOVQ, IRMMOVQ, IMRMOVQ}): valC_o = fb[9:2];
      (rawIc inside {IJXX, ICALL}):              valC_o = fb[8:1];
      default:                                   valC_o = '0;
    endcase
    if (err) begin
      icode_o       = INOP;
      ifunc_o       = 4'h0;
      rA_o          = RNONE;
      rB_o          = RNONE;
      valC_o        = '0;
      valP_o        = PC_i + 64'd1;
      instr_valid_o = 1'b1;
    end
  end

  logic [3:0] srcA;
  logic [3:0] srcB;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    unique case (1'b1)
      (icode_o inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}): srcA = rA_o;
      (icode_o inside {IRET, IPOPQ}):                   srcA = RSP;
      default:                                          srcA = RNONE;
    endcase
    unique case (1'b1)
      (icode_o inside {IRMMOVQ, IMRMOVQ, IOPQ}):        srcB = rB_o;
      (icode_o inside {ICALL, IRET, IPUSHQ, IPOPQ}):    srcB = RSP;
      default:                                          srcB = RNONE;
    endcase
  end

  y86_regfile u_rf (
    .clk  (clk_i),
    .rst  (rst_i),
    .srcA (srcA),
    .srcB (srcB),
    .dstE (dstE_i),
    .valE (valE_i),
    .dstM (dstM_i),
    .valM (valM_i),
    .valA (valA_o),
    .valB (valB_o)
  );

endmodule

// File: tb/tb_y86_fetch_decode.sv
// Directed bench for y86_fetch_decode.
// Hand-computed expectations, immediate assertions per check.
module tb_y86_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        imemWe;
  logic [63:0] imemWaddr;
  logic [7:0]  imemWdata;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;
  logic [3:0]  icode;
  logic [3:0]  ifunc;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic        instrValid;
  logic        imemError;
  logic [63:0] valA;
  logic [63:0] valB;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  y86_fetch_decode #(.IMEM_BYTES(1024)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .PC_i          (pc),
    .imem_we_i     (imemWe),
    .imem_waddr_i  (imemWaddr),
    .imem_wdata_i  (imemWdata),
    .dstE_i        (dstE),
    .valE_i        (valE),
    .dstM_i        (dstM),
    .valM_i        (valM),
    .icode_o       (icode),
    .ifunc_o       (ifunc),
    .rA_o          (rA),
    .rB_o          (rB),
    .valC_o        (valC),
    .valP_o        (valP),
    .instr_valid_o (instrValid),
    .imem_error_o  (imemError),
    .valA_o        (valA),
    .valB_o        (valB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ldb(input logic [63:0] a, input logic [7:0] d);
    imemWe    = 1'b1;
    imemWaddr = a;
    imemWdata = d;
    tick();
    imemWe    = 1'b0;
  endtask

  task automatic ldq(input logic [63:0] a, input logic [63:0] q);
    for (int i = 0; i < 8; i++) ldb(a + 64'(i), q[8*i +: 8]);
  endtask

  task automatic wrE(input logic [3:0] r, input logic [63:0] v);
    dstE = r;
    valE = v;
    tick();
    dstE = 4'hF;
  endtask

  task automatic setPc(input logic [63:0] p);
    pc = p;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    pc        = '0;
    imemWe    = 1'b0;
    imemWaddr = '0;
    imemWdata = '0;
    dstE      = 4'hF;
    valE      = '0;
    dstM      = 4'hF;
    valM      = '0;
    tick();
    rst = 1'b0;

    // irmovq $0x100, %rax at 0
    ldb(0, 8'h30); ldb(1, 8'hF0); ldq(2, 64'h100);
    // addq %rax, %rbx at 20
    ldb(20, 8'h60); ldb(21, 8'h03);
    // popq %rdx at 42
    ldb(42, 8'hB0); ldb(43, 8'h2F);
    // call 0x40 at 55
    ldb(55, 8'h80); ldq(56, 64'h40);
    // ret, bad icode, bad OPq ifunc
    ldb(64, 8'h90); ldb(66, 8'hC0); ldb(67, 8'h65);
    // rrmovq %rbp, %rax at 80
    ldb(80, 8'h20); ldb(81, 8'h50);
    // irmovq ending exactly at 1023, halt at 1023, irmovq at 1020
    ldb(1014, 8'h30); ldb(1015, 8'hF1);
    ldb(1020, 8'h30); ldb(1023, 8'h00);
    // ignored out-of-range write
    ldb(1024, 8'h30);

    setPc(20);
    chk("resetA", valA, 64'h0);
    chk("resetB", valB, 64'h0);

    setPc(0);
    chk("irIcode", 64'(icode), 64'h3);
    chk("irIfunc", 64'(ifunc), 64'h0);
    chk("irRA", 64'(rA), 64'hF);
    chk("irRB", 64'(rB), 64'h0);
    chk("irValC", valC, 64'h100);
    chk("irValP", valP, 64'd10);
    chk("irValid", 64'(instrValid), 64'h1);
    chk("irErr", 64'(imemError), 64'h0);

    wrE(0, 64'h55);
    wrE(3, 64'h7);
    setPc(20);
    chk("opIcode", 64'(icode), 64'h6);
    chk("opRA", 64'(rA), 64'h0);
    chk("opRB", 64'(rB), 64'h3);
    chk("opValA", valA, 64'h55);
    chk("opValB", valB, 64'h7);
    chk("opValP", valP, 64'd22);

    wrE(4, 64'h200);
    setPc(42);
    chk("popValA", valA, 64'h200);
    chk("popValB", valB, 64'h200);
    chk("popValP", valP, 64'd44);
    chk("popRA", 64'(rA), 64'h2);
    setPc(64);
    chk("retValA", valA, 64'h200);
    chk("retValB", valB, 64'h200);
    chk("retValP", valP, 64'd65);
    chk("retRA", 64'(rA), 64'hF);

    setPc(55);
    chk("callIcode", 64'(icode), 64'h8);
    chk("callValC", valC, 64'h40);
    chk("callValP", valP, 64'd64);
    chk("callValB", valB, 64'h200);
    chk("callValA", valA, 64'h0);

    setPc(66);
    chk("badIcValid", 64'(instrValid), 64'h0);
    chk("badIcValP", valP, 64'd67);
    setPc(67);
    chk("badFnValid", 64'(instrValid), 64'h0);

    setPc(1014);
    chk("edgeErr", 64'(imemError), 64'h0);
    chk("edgeValP", valP, 64'd1024);
    chk("edgeRA", 64'(rA), 64'hF);
    setPc(1023);
    chk("lastErr", 64'(imemError), 64'h0);
    chk("lastValP", valP, 64'd1024);

    setPc(1020);
    chk("ovErr", 64'(imemError), 64'h1);
    chk("ovIcode", 64'(icode), 64'h1);
    chk("ovValP", valP, 64'd1021);
    chk("ovValid", 64'(instrValid), 64'h1);
    chk("ovValC", valC, 64'h0);
    setPc(1024);
    chk("endErr", 64'(imemError), 64'h1);
    chk("endValP", valP, 64'd1025);
    chk("endIcode", 64'(icode), 64'h1);

    // same-edge E/M write to reg 5: M must win
    dstE = 4'd5; valE = 64'h111;
    dstM = 4'd5; valM = 64'h222;
    tick();
    dstE = 4'hF; dstM = 4'hF;
    setPc(80);
    chk("mWinsA", valA, 64'h222);
    chk("rrValB", valB, 64'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstRbp", valA, 64'h0);
    setPc(20);
    chk("rstRax", valA, 64'h0);
    chk("rstRbx", valB, 64'h0);
    setPc(64);
    chk("rstRsp", valA, 64'h0);

    setPc(80);
    dstE = 4'd5; valE = 64'h999;
    #1;
`ifdef Y86_REG_BYPASS_EN
    chk("bypE", valA, 64'h999);
`else
    chk("bypE", valA, 64'h0);
`endif
    dstM = 4'd5; valM = 64'hAAA;
    #1;
`ifdef Y86_REG_BYPASS_EN
    chk("bypM", valA, 64'hAAA);
`else
    chk("bypM", valA, 64'h0);
`endif
    tick();
    dstE = 4'hF; dstM = 4'hF;
    #1;
    chk("afterWr", valA, 64'hAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
